// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush request and control bundle between the pipeline and pipe_ctrl
interface pipe_ctrl_if #(
  parameter int Stages   = 6,
  parameter int CntWidth = 32
) ();
  logic [Stages-1:0]   stallreq;
  logic [Stages-1:0]   flushreq;
  logic [Stages-1:0]   flush_ack;
  logic [Stages-1:0]   stall;
  logic [Stages-1:0]   flush;
  logic                halt_req;
  logic                resume;
  logic                halted;
  logic [CntWidth-1:0] cycle_cnt;
  logic [CntWidth-1:0] stall_cnt;
  modport master (
    output stallreq, flushreq, halt_req, resume,
    input  flush_ack, stall, flush, halted, cycle_cnt, stall_cnt
  );
  modport slave (
    input  stallreq, flushreq, halt_req, resume,
    output flush_ack, stall, flush, halted, cycle_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-register stall/flush decode, flush arbitration, halt-drain FSM and perf counters
module pipe_ctrl #(
  parameter int Stages      = 6,
  parameter int CntWidth    = 32,
  parameter int DrainCycles = Stages - 1
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);
  localparam int DW = $clog2(DrainCycles + 2);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t              state_q, state_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [CntWidth-1:0] cyc_q, cyc_d, stc_q, stc_d;
  logic                init_q, init_d;
  logic [Stages-1:0]   sm, fm, bubble, st, fl_raw;
  logic                acc_s, acc_f, blank, hon, run, drain, hlt;
  // decode: sm marks registers at or below the oldest stall, fm those at or below the oldest redirect
  always_comb begin
    acc_s = 1'b0;
    acc_f = 1'b0;
    sm = '0;
    fm = '0;
    for (int k = Stages - 1; k >= 0; k--) begin
      acc_s = acc_s | bus.stallreq[k];
      acc_f = acc_f | bus.flushreq[k];
      sm[k] = acc_s;
      fm[k] = acc_f;
    end
    run = state_q == RUN;
    drain = state_q == DRAIN;
    hlt = state_q == HALTED;
    blank = rst | init_q;
    hon = acc_f & ~|(bus.stallreq & ~(fm >> 1)) & ~blank & ~hlt;
    bubble = (sm << 1) & ~sm;
    st = (sm & ~((hon && run) ? Stages'(1) : '0)) | (drain ? Stages'(1) : '0);
    fl_raw = bubble | (hon ? (fm & ~Stages'(1)) : '0) | (drain ? Stages'(2) : '0);
    bus.stall = blank ? '0 : hlt ? '1 : st;
    bus.flush = blank ? '1 : hlt ? '0 : (fl_raw & ~sm);
    bus.flush_ack = hon ? (fm & ~(fm >> 1)) : '0;
    bus.halted = ~blank & hlt;
  end
  // next state: halt drain sequencing and saturating counters
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    init_d = 1'b0;
    case (state_q)
      RUN: if (bus.halt_req) begin
        state_d = DRAIN;
        drain_d = DW'(DrainCycles);
      end
      DRAIN: if (hon) drain_d = DW'(DrainCycles);
        else if (~acc_s) begin
          drain_d = drain_q - DW'(1);
          if (drain_q <= DW'(1)) state_d = HALTED;
        end
      default: if (bus.resume) state_d = RUN;
    endcase
    cyc_d = cyc_q + CntWidth'(~hlt && cyc_q != '1);
    stc_d = stc_q + CntWidth'(acc_s && ~hlt && ~blank && stc_q != '1);
  end
  // state register; reset leaves a one-cycle all-flush window via init_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      drain_q <= '0;
      cyc_q <= '0;
      stc_q <= '0;
      init_q <= 1'b1;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cyc_q <= cyc_d;
      stc_q <= stc_d;
      init_q <= init_d;
    end
  end
  assign bus.cycle_cnt = cyc_q;
  assign bus.stall_cnt = stc_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl decode, arbitration, drain FSM and counters
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_ctrl_if #(.Stages(6), .CntWidth(32)) b0 ();
  pipe_ctrl_if #(.Stages(6), .CntWidth(4)) b4 ();
  pipe_ctrl #(.Stages(6), .CntWidth(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
  pipe_ctrl #(.Stages(6), .CntWidth(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_cyc = '0;
  logic exp_halted = 1'b0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    if (rst) exp_cyc = '0;
    else if (!exp_halted) exp_cyc++;
    @(posedge clk);
    #2;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    b0.stallreq = '0; b0.flushreq = '0; b0.halt_req = 0; b0.resume = 0;
    b4.stallreq = '0; b4.flushreq = '0; b4.halt_req = 0; b4.resume = 0;
    cyc(); cyc();
    #1;
    chk("rst_stall", b0.stall, 6'h00);
    chk("rst_flush", b0.flush, 6'h3f);
    chk("rst_ack", b0.flush_ack, 6'h00);
    chk("rst_halted", b0.halted, 0);
    rst = 0;
    #1;
    chk("init_stall", b0.stall, 6'h00);
    chk("init_flush", b0.flush, 6'h3f);
    chk("init_cyc", b0.cycle_cnt, 0);
    chk("init_stc", b0.stall_cnt, 0);
    cyc();
    b0.stallreq = 6'b001000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_stall", b0.stall, 6'b001111);
      chk("t1_flush", b0.flush, 6'b010000);
      cyc();
    end
    b0.stallreq = '0;
    #1;
    chk("t1_stc", b0.stall_cnt, 3);
    chk("t1_idle_stall", b0.stall, 0);
    chk("t1_idle_flush", b0.flush, 0);
    b0.flushreq = 6'b001010;
    #1;
    chk("t2_ack", b0.flush_ack, 6'b001000);
    chk("t2_flush", b0.flush, 6'b001110);
    chk("t2_stall", b0.stall, 0);
    cyc();
    b0.flushreq = 6'b000100;
    b0.stallreq = 6'b010000;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_ack_blocked", b0.flush_ack, 0);
      chk("t3_stall", b0.stall, 6'b011111);
      chk("t3_flush", b0.flush, 6'b100000);
      cyc();
    end
    b0.stallreq = '0;
    #1;
    chk("t3_ack", b0.flush_ack, 6'b000100);
    chk("t3_flush_hon", b0.flush, 6'b000110);
    cyc();
    b0.flushreq = '0;
    #1;
    chk("t3_stc", b0.stall_cnt, 5);
    b0.halt_req = 1;
    #1;
    chk("t4_run_stall", b0.stall, 0);
    cyc();
    b0.halt_req = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_drain_stall", b0.stall, 6'b000001);
      chk("t4_drain_flush", b0.flush, 6'b000010);
      chk("t4_drain_halted", b0.halted, 0);
      cyc();
    end
    exp_halted = 1;
    #1;
    chk("t4_halted", b0.halted, 1);
    chk("t4_halt_stall", b0.stall, 6'h3f);
    chk("t4_halt_flush", b0.flush, 0);
    b0.stallreq = 6'h3f;
    b0.flushreq = 6'b001000;
    #1;
    chk("t5_ign_ack", b0.flush_ack, 0);
    chk("t5_ign_stall", b0.stall, 6'h3f);
    chk("t5_ign_flush", b0.flush, 0);
    cyc(); cyc();
    b0.stallreq = '0;
    b0.flushreq = '0;
    #1;
    chk("t5_cyc_frozen", b0.cycle_cnt, exp_cyc);
    chk("t5_stc_frozen", b0.stall_cnt, 5);
    b0.halt_req = 1;
    b0.resume = 1;
    cyc();
    exp_halted = 0;
    b0.halt_req = 0;
    b0.resume = 0;
    #1;
    chk("t5_resume_halted", b0.halted, 0);
    chk("t5_resume_stall", b0.stall, 0);
    chk("t5_resume_flush", b0.flush, 0);
    cyc(); cyc();
    #1;
    chk("t5_cyc_counting", b0.cycle_cnt, exp_cyc);
    b0.halt_req = 1;
    cyc();
    b0.halt_req = 0;
    #1;
    chk("t4b_d1_stall", b0.stall, 6'b000001);
    cyc();
    b0.stallreq = 6'b000100;
    #1;
    chk("t4b_mid_stall", b0.stall, 6'b000111);
    chk("t4b_mid_flush", b0.flush, 6'b001000);
    cyc();
    b0.stallreq = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4b_drain_halted", b0.halted, 0);
      chk("t4b_drain_stall", b0.stall, 6'b000001);
      cyc();
    end
    exp_halted = 1;
    #1;
    chk("t4b_halted", b0.halted, 1);
    chk("t4b_stc", b0.stall_cnt, 6);
    chk("t6_sat", b4.cycle_cnt, 4'hf);
    chk("t6_stc4", b4.stall_cnt, 0);
    b0.resume = 1;
    cyc();
    b0.resume = 0;
    exp_halted = 0;
    b4.halt_req = 1;
    cyc();
    b4.halt_req = 0;
    #1;
    chk("t6_drain_stall", b4.stall, 6'b000001);
    chk("t6_sat_hold", b4.cycle_cnt, 4'hf);
    cyc();
    rst = 1;
    #1;
    chk("t6_rst_flush", b4.flush, 6'h3f);
    chk("t6_rst_stall", b4.stall, 0);
    cyc();
    rst = 0;
    #1;
    chk("t6_post_cyc", b4.cycle_cnt, 0);
    chk("t6_post_halted", b4.halted, 0);
    chk("t6_post_flush", b4.flush, 6'h3f);
    chk("t6_post_cyc0", b0.cycle_cnt, exp_cyc);
    cyc();
    #1;
    chk("t6_run_stall", b4.stall, 0);
    chk("t6_run_flush", b4.flush, 0);
    chk("t6_run_cyc", b4.cycle_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
